// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver and transmitter.
//   rx_state_t     - receiver FSM states
//   clks_per_bit() - integer clock cycles per bit for a given clock / baud pair
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Truncating division: the bit period is rounded down to whole clocks.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//   clk, rstn - clock, async active-low reset (both flops reset to RST_VAL)
//   i_d       - asynchronous input
//   o_q       - synchronised output (second flop)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_ff1, r_ff2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ff1 <= RST_VAL;
      r_ff2 <= RST_VAL;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver with valid/ready output.
//   clk, rstn  - clock, async active-low reset
//   sig        - serial line, idle high, asynchronous to clk
//   data       - received byte, stable while valid=1
//   valid      - byte available; consumed on valid && ready
//   ready      - consumer accept
//   is_sync    - data is all ones (only meaningful with valid)
//   frame_err  - one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    - one-cycle pulse: byte completed while previous unconsumed, new byte dropped
// CLKS_PER_BIT = CLK_FREQ / BAUD_RATE must be at least 4.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 12_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  is_sync,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_WIDTH + 1);

  // The FSM only sees s_sig one cycle after it changes, so the start
  // check fires HALF-2 counts after entering START to land the sample
  // exactly HALF cycles after s_sig went low.
  localparam logic [CW-1:0] START_LAST = CW'(HALF - 2);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);

  logic w_sig;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (sig),
    .o_q  (w_sig)
  );

  rx_state_t             r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [BW-1:0]         r_bitcnt, w_bitcnt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  // Stop-bit outcome strobes; the output stage acts on them one cycle later.
  logic                  r_good, w_good;
  logic                  r_bad, w_bad;

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid, r_sync, r_ferr, r_ovr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_good   <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_bitcnt <= w_bitcnt;
      r_shift  <= w_shift;
      r_good   <= w_good;
      r_bad    <= w_bad;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bitcnt = r_bitcnt;
    w_shift  = r_shift;
    w_good   = 1'b0;
    w_bad    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_sig) begin
          w_state  = START;
          w_cnt    = '0;
          w_bitcnt = '0;
        end
      end
      START: begin
        if (r_cnt == START_LAST) begin
          w_cnt   = '0;
          w_state = w_sig ? IDLE : DATA;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt    = '0;
          // LSB arrives first: shift right, new bit enters at the MSB.
          w_shift  = {w_sig, r_shift[DATA_WIDTH-1:1]};
          w_bitcnt = r_bitcnt + BW'(1);
          if (r_bitcnt == DATA_LAST) w_state = STOP;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt = '0;
          if (w_sig) begin
            w_good  = 1'b1;
            w_state = IDLE;
          end else begin
            w_bad   = 1'b1;
            w_state = WAIT_IDLE;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      WAIT_IDLE: begin
        // Hold off through a line break so it reports only one frame_err.
        if (w_sig) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  // Output register. r_good and r_bad are exclusive, so frame_err and
  // overrun can never pulse together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sync  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= r_bad;
      r_ovr  <= r_good && r_valid && !ready;
      if (r_good && (!r_valid || ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_sync  <= &r_shift;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign is_sync   = r_sync;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Runs at 19200 baud on a 12 MHz clock (625 clocks/bit, HALF=312) so the
// whole sequence stays short; latency expectations use the same formula
// that gives t0+11877 at the default rate.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW   = 8;
  localparam int BAUD = 19200;
  localparam int CLKF = 12_000_000;
  localparam int CPB  = CLKF / BAUD;                 // 625
  localparam int HALF = CPB / 2;                     // 312
  localparam int LAT  = 1 + HALF + (DW + 1) * CPB + 1; // valid rise, edges after t0

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sig = 1'b1;
  logic          ready = 1'b1;
  logic [DW-1:0] data;
  logic          valid, is_sync, frame_err, overrun;

  uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sig       (sig),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .is_sync   (is_sync),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int          n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_both = 0;
  int unsigned first_vcyc = 0;
  logic        valid_d = 1'b0;
  logic [8:0]  acc_q[$];

  always @(negedge clk) begin
    valid_d <= valid;
    if (valid) n_vcyc <= n_vcyc + 1;
    if (valid && !valid_d) first_vcyc <= cyc;
    if (valid && ready) acc_q.push_back({is_sync, data});
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    if (frame_err && overrun) n_both <= n_both + 1;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then step off the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns cyc value after edge t0.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned t0c);
    sig = 1'b0;
    tick(1);
    t0c = cyc;
    tick(CPB - 1);
    for (int i = 0; i < DW; i++) begin
      sig = b[i];
      tick(CPB);
    end
    sig = stop;
    tick(CPB);
  endtask

  int unsigned t0, t_dummy;
  int          base, nv;

  initial begin
    // Reset state
    tick(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_sync", is_sync, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rstn = 1'b1;
    tick(3);

    // Byte decode 0x5A
    base = acc_q.size();
    nv   = n_vcyc;
    send_frame(8'h5A, 1'b1, t0);
    tick(2);
    chk("5a_latency", first_vcyc - t0, LAT);
    chk("5a_vcycles", n_vcyc - nv, 1);
    chk("5a_count", acc_q.size() - base, 1);
    chk("5a_byte", acc_q[base], {1'b0, 8'h5A});
    chk("5a_ferr", n_ferr, 0);
    chk("5a_ovr", n_ovr, 0);

    // Sync marker then 0x3C back-to-back
    base = acc_q.size();
    send_frame(8'hFF, 1'b1, t_dummy);
    send_frame(8'h3C, 1'b1, t_dummy);
    tick(2);
    chk("b2b_count", acc_q.size() - base, 2);
    chk("b2b_ff", acc_q[base], {1'b1, 8'hFF});
    chk("b2b_3c", acc_q[base+1], {1'b0, 8'h3C});

    // Glitch shorter than half a bit
    base = acc_q.size();
    sig = 1'b0;
    tick(300);
    sig = 1'b1;
    tick(HALF + 10);
    chk("glitch_count", acc_q.size() - base, 0);
    chk("glitch_ferr", n_ferr, 0);
    chk("glitch_state", dut.r_state, IDLE);

    // Framing error followed by a 20-bit break
    base = acc_q.size();
    send_frame(8'h81, 1'b0, t_dummy);
    tick(20 * CPB);
    chk("brk_ferr", n_ferr, 1);
    chk("brk_count", acc_q.size() - base, 0);
    chk("brk_ovr", n_ovr, 0);
    chk("brk_state", dut.r_state, WAIT_IDLE);
    sig = 1'b1;
    tick(4);
    chk("brk_idle", dut.r_state, IDLE);
    send_frame(8'h42, 1'b1, t_dummy);
    tick(2);
    chk("rec_count", acc_q.size() - base, 1);
    chk("rec_byte", acc_q[$], {1'b0, 8'h42});

    // Overrun: consumer stalled across two frames
    base  = acc_q.size();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, t_dummy);
    send_frame(8'h22, 1'b1, t_dummy);
    tick(2);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data, 8'h11);
    chk("ovr_pulses", n_ovr, 1);
    chk("ovr_ferr", n_ferr, 1);
    ready = 1'b1;
    tick(1);
    chk("ovr_drop", valid, 0);
    tick(1);
    chk("ovr_count", acc_q.size() - base, 1);
    chk("ovr_byte", acc_q[$], {1'b0, 8'h11});

    // Reset during bit 3 of 0xA5 (data still holds 0x11)
    sig = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      sig = (8'hA5 >> i) & 8'h01;
      tick(CPB);
    end
    sig = 1'b0;                       // bit 3 of 0xA5
    tick(CPB / 2);
    chk("mid_state_busy", dut.r_state, DATA);
    rstn = 1'b0;
    #1;
    chk("mid_valid", valid, 0);
    chk("mid_data", data, 0);
    chk("mid_sync", is_sync, 0);
    chk("mid_ferr", frame_err, 0);
    chk("mid_ovr", overrun, 0);
    chk("mid_state", dut.r_state, IDLE);
    sig = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(3);
    base = acc_q.size();
    send_frame(8'h0F, 1'b1, t0);
    tick(2);
    chk("post_count", acc_q.size() - base, 1);
    chk("post_byte", acc_q[$], {1'b0, 8'h0F});
    chk("post_latency", first_vcyc - t0, LAT);

    chk("no_overlap", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
